// File: rtl/sbox_seq_ctrl_if.sv
// sbox_seq_ctrl_if: input word, result and shared S-box ROM port
// bundled for the S-box lookup sequencer.
interface sbox_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        rom_en;
  logic [2:0]  rom_sel;
  logic [1:0]  rom_row;
  logic [3:0]  rom_col;
  logic [3:0]  rom_dout;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    input  rom_dout,
    output in_ready,
    output out_valid,
    output out_data,
    output rom_en,
    output rom_sel,
    output rom_row,
    output rom_col
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    output rom_dout,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  rom_en,
    input  rom_sel,
    input  rom_row,
    input  rom_col
  );
endinterface

// File: rtl/sbox_seq_ctrl.sv
// sbox_seq_ctrl: one shared DES S-box ROM port, eight lookups per word.
// Optional SBOX_SEQ_CNT_EN adds done_cnt, a count of output transfers.
module sbox_seq_ctrl #(
  parameter int ROM_LAT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  sbox_seq_ctrl_if.slave bus
`ifdef SBOX_SEQ_CNT_EN
  ,
  output logic [15:0]   done_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_idx;
  logic [47:0] r_hold;
  logic [31:0] r_result;
  logic        r_tag_v   [ROM_LAT];
  logic [2:0]  r_tag_idx [ROM_LAT];

  logic        w_idle;
  logic        w_issue;
  logic        w_done;
  logic        w_accept;
  logic        w_xfer;
  logic        w_cap;
  logic [2:0]  w_cap_idx;
  logic        w_last_cap;
  logic [5:0]  w_chunk;

  assign w_idle     = (r_state == IDLE);
  assign w_issue    = (r_state == ISSUE);
  assign w_done     = (r_state == DONE);
  assign w_accept   = w_idle && bus.in_valid;
  assign w_xfer     = w_done && bus.out_ready;
  assign w_cap      = r_tag_v[ROM_LAT-1];
  assign w_cap_idx  = r_tag_idx[ROM_LAT-1];
  assign w_last_cap = w_cap && (w_cap_idx == 3'd7);

  // select the 6-bit chunk for the lookup issued this cycle
  always_comb begin
    w_chunk = 6'd0;
    unique case (r_idx)
      3'd0: w_chunk = r_hold[47:42];
      3'd1: w_chunk = r_hold[41:36];
      3'd2: w_chunk = r_hold[35:30];
      3'd3: w_chunk = r_hold[29:24];
      3'd4: w_chunk = r_hold[23:18];
      3'd5: w_chunk = r_hold[17:12];
      3'd6: w_chunk = r_hold[11:6];
      3'd7: w_chunk = r_hold[5:0];
      default: w_chunk = 6'd0;
    endcase
  end

  // in_ready is forced low while reset is asserted
  assign bus.in_ready  = w_idle && rstn;
  assign bus.out_valid = w_done;
  assign bus.out_data  = r_result;
  assign bus.rom_en    = w_issue;
  assign bus.rom_sel   = w_issue ? r_idx : 3'd0;
  assign bus.rom_row   = w_issue ?
                         {w_chunk[5], w_chunk[0]} : 2'd0;
  assign bus.rom_col   = w_issue ? w_chunk[4:1] : 4'd0;

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        if (r_idx == 3'd7) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_last_cap) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // lookup index, wraps 7 -> 0 as the last lookup issues
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_idx <= 3'd0;
    end else if (w_issue) begin
      r_idx <= r_idx + 3'd1;
    end
  end

  // holding register for the accepted word
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_hold <= 48'd0;
    end else if (w_accept) begin
      r_hold <= bus.in_data;
    end
  end

  // return tags line up with rom_dout ROM_LAT cycles later;
  // clearing them on reset drops any in-flight returns
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        r_tag_v[i]   <= 1'b0;
        r_tag_idx[i] <= 3'd0;
      end
    end else begin
      for (int i = ROM_LAT - 1; i > 0; i--) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
      r_tag_v[0]   <= w_issue;
      r_tag_idx[0] <= r_idx;
    end
  end

  // write each returned nibble into its slot, S1 in the top nibble
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_result <= 32'd0;
    end else if (w_cap) begin
      for (int i = 0; i < 8; i++) begin
        if (w_cap_idx == 3'(i)) begin
          r_result[31-4*i -: 4] <= bus.rom_dout;
        end
      end
    end
  end

`ifdef SBOX_SEQ_CNT_EN
  // completed output transfers, free-running wrap
  always_ff @(posedge clk) begin
    if (!rstn) begin
      done_cnt <= 16'd0;
    end else if (w_xfer) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end
`else
  logic w_xfer_nc;
  assign w_xfer_nc = w_xfer;
`endif

endmodule

// File: tb/tb_sbox_seq_ctrl.sv
// tb_sbox_seq_ctrl: directed vectors against ROM_LAT=1 and ROM_LAT=3
// instances, each fed by a behavioural DES S-box ROM.
module tb_sbox_seq_ctrl;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  localparam logic [63:0] SBT [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
    64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
    64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1,
    64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
    64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
    64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
    64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
    64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
    64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  function automatic logic [3:0] sbox(
    input logic [2:0] s,
    input logic [1:0] r,
    input logic [3:0] c
  );
    logic [63:0] w;
    w = SBT[{s, r}];
    return w[63 - 4*c -: 4];
  endfunction

  function automatic logic [31:0] exp_out(input logic [47:0] d);
    logic [31:0] res;
    logic [5:0]  ch;
    res = 32'd0;
    for (int i = 0; i < 8; i++) begin
      ch = d[47 - 6*i -: 6];
      res[31 - 4*i -: 4] = sbox(3'(i), {ch[5], ch[0]}, ch[4:1]);
    end
    return res;
  endfunction

  sbox_seq_ctrl_if b1 ();
  sbox_seq_ctrl_if b3 ();

  logic [1:0]  iv;
  logic [1:0]  ordy;
  logic [47:0] id [2];
  logic [1:0]  ir;
  logic [1:0]  ov;
  logic [1:0]  en;
  logic [31:0] od [2];
  logic [2:0]  sel [2];
  logic [1:0]  row [2];
  logic [3:0]  col [2];

  logic [3:0] p1;
  logic [3:0] p3 [3];

  assign b1.in_valid  = iv[0];
  assign b1.in_data   = id[0];
  assign b1.out_ready = ordy[0];
  assign b1.rom_dout  = p1;
  assign b3.in_valid  = iv[1];
  assign b3.in_data   = id[1];
  assign b3.out_ready = ordy[1];
  assign b3.rom_dout  = p3[2];

  assign ir[0]  = b1.in_ready;
  assign ov[0]  = b1.out_valid;
  assign en[0]  = b1.rom_en;
  assign od[0]  = b1.out_data;
  assign sel[0] = b1.rom_sel;
  assign row[0] = b1.rom_row;
  assign col[0] = b1.rom_col;
  assign ir[1]  = b3.in_ready;
  assign ov[1]  = b3.out_valid;
  assign en[1]  = b3.rom_en;
  assign od[1]  = b3.out_data;
  assign sel[1] = b3.rom_sel;
  assign row[1] = b3.rom_row;
  assign col[1] = b3.rom_col;

  // behavioural ROMs, not reset so in-flight data outlives a DUT reset
  always @(posedge clk) begin
    p1 <= b1.rom_en ?
          sbox(b1.rom_sel, b1.rom_row, b1.rom_col) : 4'h0;
  end

  always @(posedge clk) begin
    p3[0] <= b3.rom_en ?
             sbox(b3.rom_sel, b3.rom_row, b3.rom_col) : 4'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

`ifdef SBOX_SEQ_CNT_EN
  logic [15:0] cnt1;
  logic [15:0] cnt3;
`endif

  sbox_seq_ctrl #(.ROM_LAT(1)) u_dut1 (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (b1)
`ifdef SBOX_SEQ_CNT_EN
    ,
    .done_cnt (cnt1)
`endif
  );

  sbox_seq_ctrl #(.ROM_LAT(3)) u_dut3 (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (b3)
`ifdef SBOX_SEQ_CNT_EN
    ,
    .done_cnt (cnt3)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer [2];

  task automatic check(
    input string       tag,
    input logic [47:0] got,
    input logic [47:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one word through DUT w; hold>0 keeps out_ready low that long
  task automatic run_xfer(
    input int          w,
    input logic [47:0] d,
    input logic [31:0] expd,
    input int          exp_cyc,
    input int          hold
  );
    int k;
    int n;
    logic [5:0]  ch;
    logic [31:0] held;
    ordy[w] = (hold == 0);
    @(negedge clk);
    id[w] = d;
    iv[w] = 1'b1;
    #1;
    check("in_ready_idle", 48'(ir[w]), 48'd1);
    @(posedge clk);
    #1;
    iv[w] = 1'b0;
    k = 1;
    n = 0;
    while (!ov[w] && k < 40) begin
      if (en[w]) begin
        ch = d[47 - 6*n -: 6];
        check("rom_sel", 48'(sel[w]), 48'(n));
        check("rom_row", 48'(row[w]), 48'({ch[5], ch[0]}));
        check("rom_col", 48'(col[w]), 48'(ch[4:1]));
        n++;
      end
      check("in_ready_busy", 48'(ir[w]), 48'd0);
      @(posedge clk);
      #1;
      k++;
    end
    check("out_valid_cycle", 48'(k), 48'(exp_cyc));
    check("issue_count", 48'(n), 48'd8);
    check("out_data", 48'(od[w]), 48'(expd));
    if (hold > 0) begin
      held = od[w];
      for (int c = 0; c < hold; c++) begin
        if (c == 5) begin
          id[w] = ~d;
          iv[w] = 1'b1;
        end
        if (c == 7) begin
          iv[w] = 1'b0;
        end
        @(posedge clk);
        #1;
        check("hold_valid", 48'(ov[w]), 48'd1);
        check("hold_data", 48'(od[w]), 48'(held));
        check("hold_ready", 48'(ir[w]), 48'd0);
      end
      @(negedge clk);
      ordy[w] = 1'b1;
    end
    @(posedge clk);
    #1;
    n_xfer[w]++;
    check("post_ready", 48'(ir[w]), 48'd1);
    check("post_valid", 48'(ov[w]), 48'd0);
  endtask

  initial begin
    int k;
    rstn      = 1'b0;
    iv        = 2'b00;
    ordy      = 2'b11;
    id[0]     = 48'd0;
    id[1]     = 48'd0;
    n_xfer[0] = 0;
    n_xfer[1] = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 48'(ir), 48'd0);
    check("rst_out_valid", 48'(ov), 48'd0);
    check("rst_rom_en", 48'(en), 48'd0);
    check("rst_out_data", 48'(od[0]), 48'd0);
    check("rst_rom_sel", 48'(sel[0]), 48'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rel_in_ready", 48'(ir), 48'd3);

    run_xfer(0, 48'h0, 32'hEFA72C4D, 10, 0);
    run_xfer(0, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, 10, 0);
    run_xfer(0, 48'h0123_4567_89AB,
             exp_out(48'h0123_4567_89AB), 10, 0);
    run_xfer(1, 48'h0, 32'hEFA72C4D, 12, 0);
    run_xfer(1, 48'hA5C3_0F96_E17B,
             exp_out(48'hA5C3_0F96_E17B), 12, 0);

    run_xfer(0, 48'h0, 32'hEFA72C4D, 10, 20);
    run_xfer(0, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, 10, 0);

    // reset in cycle T+5 of a transfer on the ROM_LAT=3 instance
    @(negedge clk);
    id[1] = 48'hFFFF_FFFF_FFFF;
    iv[1] = 1'b1;
    @(posedge clk);
    #1;
    iv[1] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 48'(ov[1]), 48'd0);
    check("mid_rst_rom_en", 48'(en[1]), 48'd0);
    check("mid_rst_data", 48'(od[1]), 48'd0);
    check("mid_rst_sel", 48'(sel[1]), 48'd0);
    check("mid_rst_row", 48'(row[1]), 48'd0);
    check("mid_rst_col", 48'(col[1]), 48'd0);
    check("mid_rst_ready", 48'(ir[1]), 48'd0);
    n_xfer[0] = 0;
    n_xfer[1] = 0;
    @(negedge clk);
    rstn  = 1'b1;
    id[1] = 48'h0;
    iv[1] = 1'b1;
    #1;
    check("rel_ready", 48'(ir[1]), 48'd1);
    @(posedge clk);
    #1;
    iv[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("no_stale_data", 48'(od[1]), 48'd0);
      @(posedge clk);
      #1;
    end
    k = 4;
    while (!ov[1] && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rst_xfer_cycle", 48'(k), 48'd12);
    check("rst_xfer_data", 48'(od[1]), 48'hEFA72C4D);
    @(posedge clk);
    #1;
    n_xfer[1]++;
    check("rst_xfer_done", 48'(ir[1]), 48'd1);

    run_xfer(0, 48'h0, 32'hEFA72C4D, 10, 0);
    run_xfer(0, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, 10, 0);
    run_xfer(0, 48'h0, 32'hEFA72C4D, 10, 0);

`ifdef SBOX_SEQ_CNT_EN
    check("done_cnt1", 48'(cnt1), 48'(n_xfer[0]));
    check("done_cnt3", 48'(cnt3), 48'(n_xfer[1]));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
